jk_register_bank: RTL and testbench

- Parametrised, multi-mode successor to the single-bit JK flip-flop.
- WIDTH channels with per-bit JK control, parallel load, serial shift and a modulo up/down count mode with terminal-count flag.
- Replaces discrete JK chains in the irrigation controller's valve-state latches, sequence shifters and watering-interval timers.

---
 rtl/jk_register_bank.sv | 91 +++++++++
 tb/tb_jk_register_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// Multi-mode WIDTH-bit register: per-bit JK, parallel load, serial shift and
// modulo up/down count with terminal-count flag. Async clear/preset, clear dominant.
module jk_register_bank #(
    parameter int               WIDTH        = 4,
    parameter int               MOD          = 10,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PRESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    input  logic             SER_IN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             SER_OUT
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_eff;
    logic [WIDTH-1:0] q_next;
    logic             pv_arm;
    logic             clk_seen;

    // If RESET is released while PRESET is still low, the stored value is 0 but the
    // register must come out of preset holding PRESET_VALUE. pv_arm records that the
    // last PRESET release happened with RESET high; it stands in for q_reg until the
    // first clock edge rewrites q_reg from q_eff.
    always_ff @(posedge PRESET or negedge RESET) begin
        if (!RESET) pv_arm <= 1'b0;
        else        pv_arm <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET or negedge PRESET) begin
        if (!RESET || !PRESET) clk_seen <= 1'b0;
        else                   clk_seen <= 1'b1;
    end

    always_comb begin
        q_eff = q_reg;
        if (!RESET)                  q_eff = '0;
        else if (!PRESET)            q_eff = PRESET_VALUE;
        else if (pv_arm && !clk_seen) q_eff = PRESET_VALUE;
    end

    always_comb begin
        q_next = q_eff;
        if (EN) begin
            case (MODE)
                MODE_JK:    q_next = (J & ~q_eff) | (~K & q_eff);
                MODE_LOAD:  q_next = D;
                MODE_SHIFT: q_next = DIR ? {SER_IN, q_eff[WIDTH-1:1]}
                                         : {q_eff[WIDTH-2:0], SER_IN};
                MODE_COUNT: begin
                    if (!DIR)
                        q_next = (q_eff >= CNT_TOP) ? '0 : q_eff + WIDTH'(1);
                    else
                        q_next = (q_eff == '0 || {1'b0, q_eff} >= MOD_EXT)
                                 ? CNT_TOP : q_eff - WIDTH'(1);
                end
                default:    q_next = q_eff;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET or negedge PRESET) begin
        if (!RESET)       q_reg <= '0;
        else if (!PRESET) q_reg <= PRESET_VALUE;
        else              q_reg <= q_next;
    end

    assign Q       = q_eff;
    assign Qn      = ~q_eff;
    assign SER_OUT = DIR ? q_eff[0] : q_eff[WIDTH-1];
    assign TC      = (MODE == MODE_COUNT) && EN &&
                     (DIR ? (q_eff == '0) : (q_eff == CNT_TOP));

endmodule

// File: tb/tb_jk_register_bank.sv
// Bench for jk_register_bank: directed scenarios plus randomized traffic,
// compared against an integer-arithmetic reference model.
module tb_jk_register_bank;

    localparam int W   = 4;
    localparam int MD  = 10;
    localparam int PV  = 15;
    localparam int TOP = (1 << W);

    logic         CLK = 1'b0;
    logic         RESET, PRESET, EN, DIR, SER_IN;
    logic [1:0]   MODE;
    logic [W-1:0] J, K, D;
    logic [W-1:0] Q, Qn;
    logic         TC, SER_OUT;

    int n_tests = 0;
    int n_fail  = 0;
    int m       = 0;

    jk_register_bank #(.WIDTH(W), .MOD(MD), .PRESET_VALUE(4'hF)) dut (
        .CLK(CLK), .RESET(RESET), .PRESET(PRESET), .EN(EN), .MODE(MODE),
        .DIR(DIR), .J(J), .K(K), .D(D), .SER_IN(SER_IN),
        .Q(Q), .Qn(Qn), .TC(TC), .SER_OUT(SER_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_next();
        int r;
        r = m;
        if (!EN) return m;
        case (MODE)
            2'd0: begin
                r = 0;
                for (int i = 0; i < W; i++) begin
                    int b;
                    int nb;
                    b = (m >> i) & 1;
                    if (J[i] && K[i]) nb = 1 - b;
                    else if (J[i])    nb = 1;
                    else if (K[i])    nb = 0;
                    else              nb = b;
                    r += nb << i;
                end
            end
            2'd1: r = int'(D);
            2'd2: r = DIR ? (int'(SER_IN) * (TOP / 2) + m / 2)
                          : ((m * 2 + int'(SER_IN)) % TOP);
            default: begin
                if (!DIR) r = (m >= MD - 1) ? 0 : m + 1;
                else      r = (m == 0 || m >= MD) ? MD - 1 : m - 1;
            end
        endcase
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        int exp_tc;
        int exp_ser;
        exp_tc  = (MODE == 2'd3 && EN && ((!DIR && m == MD - 1) || (DIR && m == 0))) ? 1 : 0;
        exp_ser = DIR ? (m % 2) : (m / (TOP / 2));
        chk({tag, "_q"},   Q,       m);
        chk({tag, "_qn"},  Qn,      (TOP - 1) - m);
        chk({tag, "_tc"},  TC,      exp_tc);
        chk({tag, "_ser"}, SER_OUT, exp_ser);
    endtask

    task automatic tick(input string tag);
        int nxt;
        nxt = model_next();
        @(posedge CLK);
        m = nxt;
        @(negedge CLK);
        check_outputs(tag);
    endtask

    task automatic load(input int v);
        EN = 1'b1; MODE = 2'd1; D = W'(v);
        tick("load");
    endtask

    initial begin
        RESET = 1'b0; PRESET = 1'b1; EN = 1'b0; MODE = 2'd0; DIR = 1'b0;
        J = '0; K = '0; D = '0; SER_IN = 1'b0;
        #2;
        check_outputs("rst");
        MODE = 2'd3; EN = 1'b1; DIR = 1'b1; #1;
        chk("rst_tc_down", TC, 1);
        MODE = 2'd0; EN = 1'b0; DIR = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        tick("hold_after_rst");

        // async priority, released reset-first then preset
        RESET = 1'b0; PRESET = 1'b0; #1;
        chk("async_both_q", Q, 0);
        RESET = 1'b1; #1;
        m = PV;
        chk("async_pre_q", Q, PV);
        chk("async_pre_qn", Qn, 0);
        PRESET = 1'b1; #1;
        chk("async_rel_q", Q, PV);
        tick("async_hold");
        // released preset-first: reset must win
        RESET = 1'b0; PRESET = 1'b0; #1;
        PRESET = 1'b1; #1;
        chk("async_rst_dom1", Q, 0);
        RESET = 1'b1; #1;
        m = 0;
        chk("async_rst_dom2", Q, 0);
        tick("async_hold2");

        // JK
        load(5);
        MODE = 2'd0; J = 4'b1100; K = 4'b1010;
        tick("jk");
        chk("jk_lit", Q, 4'b1101);
        EN = 1'b0; J = 4'hF; K = 4'hF;
        tick("jk_hold");
        chk("jk_hold_lit", Q, 4'b1101);

        // count up
        load(7);
        MODE = 2'd3; DIR = 1'b0;
        tick("up8");
        tick("up9");
        chk("up9_tc_lit", TC, 1);
        tick("up0");
        chk("up0_lit", Q, 0);
        tick("up1");
        load(12);
        MODE = 2'd3; DIR = 1'b0;
        tick("up_oor");
        chk("up_oor_lit", Q, 0);

        // count down
        load(1);
        MODE = 2'd3; DIR = 1'b1;
        tick("dn0");
        chk("dn0_tc_lit", TC, 1);
        tick("dn9");
        chk("dn9_lit", Q, 9);
        tick("dn8");
        load(13);
        MODE = 2'd3; DIR = 1'b1;
        tick("dn_oor");
        chk("dn_oor_lit", Q, 9);

        // shift
        load(8);
        MODE = 2'd2; DIR = 1'b0;
        SER_IN = 1'b1; tick("shl1");
        SER_IN = 1'b0; tick("shl2");
        SER_IN = 1'b1; tick("shl3");
        SER_IN = 1'b1; tick("shl4");
        chk("shl_final_lit", Q, 4'b1011);
        DIR = 1'b1; SER_IN = 1'b0;
        tick("shr");
        chk("shr_lit", Q, 4'b0101);
        chk("shr_ser_lit", SER_OUT, 1);

        // reset mid-count
        load(5);
        MODE = 2'd3; DIR = 1'b0; EN = 1'b1;
        RESET = 1'b0; #1;
        m = 0;
        chk("midrst_q", Q, 0);
        chk("midrst_tc", TC, 0);
        RESET = 1'b1;
        tick("midrst_next");
        chk("midrst_next_lit", Q, 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            EN     = ($urandom_range(0, 7) != 0);
            MODE   = 2'($urandom_range(0, 3));
            DIR    = 1'($urandom_range(0, 1));
            J      = W'($urandom);
            K      = W'($urandom);
            D      = W'($urandom);
            SER_IN = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 24);
            if (r == 0) begin
                RESET = 1'b0; #1; m = 0;
                chk("rnd_rst", Q, m);
                RESET = 1'b1; #1;
            end else if (r == 1) begin
                PRESET = 1'b0; #1; m = PV;
                chk("rnd_pre", Q, m);
                PRESET = 1'b1; #1;
            end else if (r == 2) begin
                RESET = 1'b0; PRESET = 1'b0; #1;
                if ($urandom_range(0, 1) == 1) begin
                    RESET = 1'b1; #1; PRESET = 1'b1; m = PV;
                end else begin
                    PRESET = 1'b1; #1; RESET = 1'b1; m = 0;
                end
                #1;
                chk("rnd_both", Q, m);
            end
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
